// File: rtl/led_wave_gen.sv
// led_wave_gen: N-channel sigma-delta LED pattern generator (off, breathe, chase, activity flash)
module led_wave_gen #(
    parameter int NUM_LEDS   = 4,
    parameter int CNT_W      = 28,
    parameter int ENV_W      = 6,
    parameter int PHASE_STEP = 1_000_000,
    parameter int CHASE_SH   = 24,
    parameter int DECAY_SH   = 18
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic [1:0]          i_mode,
    input  logic                i_act_pulse,
    output logic [NUM_LEDS-1:0] o_led
);
    localparam int IDX_W = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ENV_W-1:0] lvl_q, lvl_d;
    logic             chase_tick, decay_tick;
    assign chase_tick = &cnt_q[CHASE_SH-1:0];
    assign decay_tick = &cnt_q[DECAY_SH-1:0];
    // Shared time base, chase index and activity level; a pulse beats a coincident decay tick
    always_comb begin
        cnt_d = i_en ? cnt_q + 1'b1 : '0;
        idx_d = !i_en ? '0 : !chase_tick ? idx_q : (idx_q == IDX_W'(NUM_LEDS - 1)) ? '0 : idx_q + 1'b1;
        lvl_d = !i_en ? '0 : (i_act_pulse && i_mode == 2'd3) ? '1 : (decay_tick && lvl_q != '0) ? lvl_q - 1'b1 : lvl_q;
    end
    // Shared state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            lvl_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            lvl_q <= lvl_d;
        end
    end
    for (genvar k = 0; k < NUM_LEDS; k++) begin : g_ch
        logic [CNT_W-1:0] phase;
        logic [ENV_W-1:0] ramp, env;
        logic [ENV_W:0]   acc_q, acc_d;
        assign phase = cnt_q + CNT_W'(k * PHASE_STEP);
        assign ramp  = phase[CNT_W-2 -: ENV_W];
        // Envelope select and first-order sigma-delta step; the carry bit is the LED drive
        always_comb begin
            env   = (i_mode == 2'd1) ? (phase[CNT_W-1] ? ramp : ~ramp) :
                    (i_mode == 2'd2) ? ((idx_q == IDX_W'(k)) ? '1 : '0) :
                    (i_mode == 2'd3) ? lvl_q : '0;
            acc_d = i_en ? {1'b0, acc_q[ENV_W-1:0]} + {1'b0, env} : '0;
        end
        // Per-channel accumulator
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) acc_q <= '0;
            else          acc_q <= acc_d;
        end
        assign o_led[k] = acc_q[ENV_W];
    end
endmodule

// File: tb/tb_led_wave_gen.sv
// tb_led_wave_gen: randomized bench comparing led_wave_gen against an arithmetic model every cycle
module tb_led_wave_gen;
    localparam int NL = 4, CW = 12, EW = 4, PS = 256, CS = 6, DS = 4;
    localparam int EMAX = (1 << EW) - 1;
    logic          clk = 0, rst_n = 0, en = 0, act = 0;
    logic [1:0]    mode = 0;
    logic [NL-1:0] led;
    int            pass_cnt = 0, total_cnt = 0, cyc = 0;
    int            m_cnt = 0, m_lvl = 0;
    int            m_acc[NL];

    led_wave_gen #(.NUM_LEDS(NL), .CNT_W(CW), .ENV_W(EW), .PHASE_STEP(PS), .CHASE_SH(CS), .DECAY_SH(DS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_act_pulse(act), .o_led(led)
    );

    always #5 clk = ~clk;

    function automatic int env_of(int k);
        int c, t;
        case (mode)
            2'd1: begin
                c = (m_cnt + k * PS) % (1 << CW);
                t = (c / (1 << (CW - 1 - EW))) % (1 << EW);
                return (c >= (1 << (CW - 1))) ? t : EMAX - t;
            end
            2'd2: return (k == (m_cnt / (1 << CS)) % NL) ? EMAX : 0;
            2'd3: return m_lvl;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !en) begin
            m_cnt <= 0;
            m_lvl <= 0;
            for (int k = 0; k < NL; k++) m_acc[k] <= 0;
        end else begin
            for (int k = 0; k < NL; k++) m_acc[k] <= m_acc[k] % (1 << EW) + env_of(k);
            if (act && mode == 2'd3) m_lvl <= EMAX;
            else if (m_cnt % (1 << DS) == (1 << DS) - 1 && m_lvl > 0) m_lvl <= m_lvl - 1;
            m_cnt <= (m_cnt + 1) % (1 << CW);
        end
    end

    task automatic chk(string name, int got, int exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    endtask

    function automatic logic [NL-1:0] model_led();
        logic [NL-1:0] v;
        for (int k = 0; k < NL; k++) v[k] = (m_acc[k] >= (1 << EW));
        return v;
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            chk("led_vs_model", int'(led), int'(model_led()));
        end
    endtask

    task automatic restart(logic [1:0] m);
        en = 0;
        step(1);
        chk("clear_led", int'(led), 0);
        en = 1;
        mode = m;
    endtask

    initial begin
        int hi, hs[NL];
        step(3);
        rst_n = 1; en = 1; mode = 2'd1;
        step(37);
        @(negedge clk);
        #2 rst_n = 0;
        #1 chk("async_reset_led", int'(led), 0);
        step(2);
        rst_n = 1; en = 1; mode = 2'd1;
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (i == 0) chk("edge1_led0", int'(led[0]), 0);
            if (i == 1) chk("edge2_led0", int'(led[0]), 1);
            hi += int'(led[0]);
        end
        chk("first16_highs", hi, 15);
        for (int i = 0; i < 4096; i++) begin
            act = ($urandom_range(0, 7) == 0);
            step(1);
        end
        act = 0;
        restart(2'd2);
        hi = 0;
        for (int k = 0; k < NL; k++) hs[k] = 0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            for (int k = 0; k < NL; k++) hs[k] += int'(led[k]);
        end
        chk("chase_win0_led0", hs[0], 60);
        chk("chase_win0_others", hs[1] + hs[2] + hs[3], 0);
        for (int i = 0; i < 448; i++) begin
            act = ($urandom_range(0, 5) == 0);
            step(1);
        end
        act = 0;
        restart(2'd3);
        step(10);
        act = 1;
        step(1);
        act = 0;
        chk("model_lvl_after_pulse", m_lvl, EMAX);
        step(300);
        chk("model_lvl_decayed", m_lvl, 0);
        hi = 0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            hi += $countones(led);
        end
        chk("activity_dark", hi, 0);
        act = 1;
        step(1);
        act = 0;
        step(20);
        for (int i = 0; i < 32 && m_cnt % (1 << DS) != (1 << DS) - 1; i++) step(1);
        chk("model_at_decay_tick", m_cnt % (1 << DS), (1 << DS) - 1);
        act = 1;
        step(1);
        act = 0;
        chk("model_pulse_wins", m_lvl, EMAX);
        step(50);
        mode = 2'd1;
        step(200);
        en = 0; act = 1; mode = 2'd3;
        step(1);
        act = 0;
        chk("pulse_dropped_led", int'(led), 0);
        en = 1;
        step(40);
        restart(2'd1);
        step(999);
        en = 0;
        step(1);
        chk("en_drop_led", int'(led), 0);
        en = 1;
        step(1);
        chk("restart_edge1_led0", int'(led[0]), 0);
        step(1);
        chk("restart_edge2_led0", int'(led[0]), 1);
        for (int t = 1; t <= 3; t++) begin
            mode = 2'(t);
            act = 1;
            step(1);
            act = 0;
            step($urandom_range(20, 200));
            mode = 2'd0;
            for (int k = 0; k < NL; k++) hs[k] = 0;
            for (int i = 0; i < 40; i++) begin
                step(1);
                for (int k = 0; k < NL; k++) hs[k] += int'(led[k]);
            end
            for (int k = 0; k < NL; k++) chk("off_residue", int'(hs[k] <= 1), 1);
        end
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            act = ($urandom_range(0, 7) == 0);
            en = ($urandom_range(0, 299) != 0);
            step(1);
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/led_wave_gen.md
# led_wave_gen

Parametrised N-channel LED pattern generator for board status indication. It drives NUM_LEDS outputs with first-order sigma-delta brightness modulation. Runtime-selectable modes: off, phase-shifted breathing wave, rotating chase, and activity flash with linear decay. It sits beside the UART/FIFO/DDR datapath and takes only a mode select and an activity strobe from it, e.g. a byte-received pulse.

## Interface

Parameters:
- NUM_LEDS, 4: number of LED channels (≥1).
- CNT_W, 28: time-base counter width (≥ ENV_W+2).
- ENV_W, 6: brightness resolution in bits.
- PHASE_STEP, 1_000_000: time-base offset between adjacent channels in breathe mode.
- CHASE_SH, 24: chase advances once every 2^CHASE_SH cycles (CHASE_SH ≤ CNT_W).
- DECAY_SH, 18: activity level drops by 1 every 2^DECAY_SH cycles (DECAY_SH ≤ CNT_W).

Ports:
- i_clk, input, 1: system clock (100 MHz).
- i_rst_n, input, 1: reset, asynchronous, active-low.
- i_en, input, 1: enable. Low means synchronous clear of all state.
- i_mode, input, 2: 0 OFF, 1 BREATHE, 2 CHASE, 3 ACTIVITY.
- i_act_pulse, input, 1: single-cycle activity strobe. Used only in ACTIVITY mode; ignored otherwise.
- o_led, output, NUM_LEDS: LED drive, registered, active-high.

## Operation

- State:
  - cnt[CNT_W-1:0]: free-running time base.
  - acc[k][ENV_W:0]: one accumulator per channel.
  - idx: chase index, range 0..NUM_LEDS-1.
  - lvl[ENV_W-1:0]: activity level.
- Reset (i_rst_n low, async): all state 0, o_led = 0.
- i_en low (sync): all state cleared to 0 at the next edge. o_led is 0 one cycle later.
- i_en high: cnt increments by 1 each cycle and wraps mod 2^CNT_W.
- Tick definitions:
  - Chase tick: cnt[CHASE_SH-1:0] all ones.
  - Decay tick: cnt[DECAY_SH-1:0] all ones.
- Per-channel envelope env[k] (ENV_W bits, combinational from current state):
  - OFF: 0.
  - BREATHE: c = cnt + k·PHASE_STEP (mod 2^CNT_W). env = c[CNT_W-1] ? c[CNT_W-2 -: ENV_W] : ~c[CNT_W-2 -: ENV_W]. This gives a triangle wave per channel.
  - CHASE: env = all ones if k == idx, else 0.
  - ACTIVITY: env = lvl on every channel.
- Sigma-delta update:
  - acc[k] <= {1'b0, acc[k][ENV_W-1:0]} + env[k]; the sum is ENV_W+1 bits and cannot overflow.
  - o_led[k] = acc[k][ENV_W].
  - Long-run duty = env/2^ENV_W. Maximum duty is (2^ENV_W−1)/2^ENV_W; full-on is not required.
- Chase index:
  - On a chase tick, in any mode, idx <= (idx == NUM_LEDS-1) ? 0 : idx+1.
  - idx holds otherwise. With NUM_LEDS = 1, idx stays 0.
- Activity level:
  - i_act_pulse with mode == 3: lvl <= all ones.
  - Otherwise, on a decay tick with lvl ≠ 0: lvl <= lvl − 1.
  - Pulse and decay tick in the same cycle: the pulse wins, so lvl = all ones.
  - lvl saturates at 0 and never wraps.
  - Outside mode 3, lvl continues to decay and cannot be raised.
- Mode change:
  - No state is cleared; cnt, idx, lvl and acc carry over.
  - The new envelope applies from the edge following the change.
  - Leftover accumulator residue may produce at most one extra high cycle per channel after a switch to OFF.

## Timing

- Single clock domain, no handshakes. o_led comes directly from flops with no output combinational logic.
- Latency: env is sampled at edge n, reflected in acc at edge n+1, and visible on o_led after edge n+1.
- After reset release with i_en = 1 and mode BREATHE, channel 0 has env = all ones from cycle 0:
  - acc after edge 1 = 2^ENV_W−1, o_led[0] = 0.
  - Edge 2: o_led[0] = 1.
- Chase tick at cnt = 2^CHASE_SH−1 changes idx at the same edge. The new idx affects env from the following cycle.
- cnt wrap from all ones to 0 is continuous; it causes no glitch or reset of acc.
- i_en deasserted mid-pattern: state is cleared at the next edge regardless of mode or pending pulse.
- i_act_pulse in the same cycle as i_en low is dropped.

## Test plan

Bench parameters: NUM_LEDS=4, CNT_W=12, ENV_W=4, PHASE_STEP=256, CHASE_SH=6, DECAY_SH=4.

1. Reset and enable: assert i_rst_n=0 mid-clock → o_led=0 immediately. Then release with i_en=1, mode=1 → o_led[0]=0 after edge 1, 1 after edge 2, and over 16 cycles o_led[0] is high 15 times.
2. Breathe phase: run 4096 cycles in mode 1, count high cycles of each channel per 256-cycle window → each channel's count equals the triangle envelope duty, and each channel is offset by 256 cycles from its neighbour.
3. Chase: mode 2, 512 cycles → idx sequence 0,1,2,3,0,… advancing every 64 cycles. In each 64-cycle window only o_led[idx] toggles, with 60/64 duty ±1; the other channels stay at 0 apart from residue.
4. Activity decay: mode 3, one pulse at cycle 10 → lvl=15, then decrements at each cnt[3:0]==15 tick to reach 0 after 15 ticks and stays there. A pulse coincident with a decay tick → lvl=15.
5. Enable drop: mode 1, i_en=0 at cycle 1000 for 1 cycle → cnt, acc, idx and lvl all 0 at the next edge, o_led=0, and the pattern restarts as in scenario 1.
6. Mode switch to OFF at an arbitrary cycle → each channel shows at most one further high cycle, then 0 indefinitely; cnt keeps counting.
